// File: rtl/sha3_pad_packer.sv
// -----------------------------------------------------------------------------
// sha3_pad_packer
//
// Front end of the SHA3 hash engine. It takes a raw byte message on a 16-bit
// AXI-stream, appends SHA3 padding (domain suffix 0x06, pad10*1 final 0x80),
// and emits only whole rate-sized blocks of 16-bit words. The sponge core
// therefore never sees a partial block.
//
// Ports
//   ACLK      clock
//   ARESET    synchronous, active-high reset
//   USER      rate select latched at message start:
//             0 = SHA3-224, 1 = SHA3-256, 2 = SHA3-384, 3 = SHA3-512
//   s_tdata   message bytes; first byte in [7:0], second byte in [15:8]
//   s_tkeep   byte valid; only the tlast word may be partial
//   s_tvalid  input valid
//   s_tlast   last word of the message
//   s_tready  input ready
//   m_tdata   padded block word (registered)
//   m_tvalid  output valid
//   m_tready  downstream ready
//   m_tlast   last word of every block
//   m_tuser   last word of the final block of a message
//   busy      high from the first accepted word until the final word leaves
// -----------------------------------------------------------------------------
module sha3_pad_packer #(
   parameter int unsigned WIDTH = 16
) (
   input  logic               ACLK,
   input  logic               ARESET,
   input  logic [1:0]         USER,
   input  logic [WIDTH-1:0]   s_tdata,
   input  logic [WIDTH/8-1:0] s_tkeep,
   input  logic               s_tvalid,
   input  logic               s_tlast,
   output logic               s_tready,
   output logic [WIDTH-1:0]   m_tdata,
   output logic               m_tvalid,
   input  logic               m_tready,
   output logic               m_tlast,
   output logic               m_tuser,
   output logic               busy
);

   typedef enum logic [0:0] {
      ST_DATA = 1'b0,
      ST_PAD  = 1'b1
   } state_t;

   state_t       state;
   state_t       state_nx;
   logic         pad_first;
   logic         pad_first_nx;
   logic [6:0]   wcnt;
   logic [1:0]   mode;
   logic         in_msg;      // at least one non-last word of a message accepted

   logic [1:0]   cur_mode;
   logic [6:0]   rate;
   logic         at_last;
   logic         out_free;
   logic         s_fire;

   logic             ld;
   logic [WIDTH-1:0] ld_data;
   logic             ld_last;
   logic             ld_user;

   // Before the first word of a message is accepted the latched mode is stale,
   // so the rate of that first word must come straight from USER.
   assign cur_mode = (state == ST_DATA && !in_msg) ? USER : mode;

   always_comb begin
      case (cur_mode)
         2'd0:    rate = 7'd72;
         2'd1:    rate = 7'd68;
         2'd2:    rate = 7'd52;
         default: rate = 7'd36;
      endcase
   end

   assign at_last  = (wcnt == rate - 7'd1);
   assign out_free = !m_tvalid || m_tready;
   assign s_tready = (state == ST_DATA) && out_free;
   assign s_fire   = s_tvalid && s_tready;

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state     <= ST_DATA;
         pad_first <= 1'b0;
      end else begin
         state     <= state_nx;
         pad_first <= pad_first_nx;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_nx     = state;
      pad_first_nx = pad_first;
      case (state)
         ST_DATA: begin
            if (s_fire && s_tlast) begin
               if (s_tkeep[1] || s_tkeep == 2'b00) begin
                  // Whole-word or empty tail: the 0x06 suffix starts a pad word.
                  state_nx     = ST_PAD;
                  pad_first_nx = 1'b1;
               end else if (!at_last) begin
                  // Single-byte tail already carried the 0x06 suffix.
                  state_nx     = ST_PAD;
                  pad_first_nx = 1'b0;
               end
            end
         end
         ST_PAD: begin
            if (out_free) begin
               pad_first_nx = 1'b0;
               if (at_last) begin
                  state_nx = ST_DATA;
               end
            end
         end
         default: begin
            state_nx     = ST_DATA;
            pad_first_nx = 1'b0;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Output word generation (value loaded into the output register)
   // ---------------------------------------------------------------------------
   always_comb begin
      ld      = 1'b0;
      ld_data = '0;
      ld_last = 1'b0;
      ld_user = 1'b0;
      case (state)
         ST_DATA: begin
            if (s_fire) begin
               if (s_tkeep[1]) begin
                  // keep = 10 is handled as a full word.
                  ld      = 1'b1;
                  ld_data = s_tdata;
                  ld_last = at_last;
               end else if (s_tkeep[0]) begin
                  ld      = 1'b1;
                  ld_data = {(at_last ? 8'h86 : 8'h06), s_tdata[7:0]};
                  ld_last = at_last;
                  ld_user = at_last;
               end
            end
         end
         ST_PAD: begin
            if (out_free) begin
               ld      = 1'b1;
               ld_data = {(at_last ? 8'h80 : 8'h00), (pad_first ? 8'h06 : 8'h00)};
               ld_last = at_last;
               ld_user = at_last;
            end
         end
         default: begin
            ld = 1'b0;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         m_tdata  <= '0;
         m_tvalid <= 1'b0;
         m_tlast  <= 1'b0;
         m_tuser  <= 1'b0;
         busy     <= 1'b0;
         wcnt     <= '0;
         mode     <= '0;
         in_msg   <= 1'b0;
      end else begin
         if (out_free) begin
            m_tvalid <= ld;
         end
         if (ld) begin
            m_tdata <= ld_data;
            m_tlast <= ld_last;
            m_tuser <= ld_user;
            wcnt    <= at_last ? 7'd0 : wcnt + 7'd1;
         end

         if (s_fire) begin
            in_msg <= !s_tlast;
            if (!in_msg) begin
               mode <= USER;
            end
         end

         // A new message may start in the same cycle the previous one's final
         // word leaves, so the set has priority over the clear.
         if (s_fire && !in_msg) begin
            busy <= 1'b1;
         end else if (m_tvalid && m_tready && m_tuser) begin
            busy <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sha3_pad_packer.sv
// -----------------------------------------------------------------------------
// tb_sha3_pad_packer
//
// Directed bench for sha3_pad_packer. Each table record describes one message
// (mode, body words, tail word/keep, downstream ready pattern) together with
// hand-computed output length, first word and last word. The full output
// stream is also compared against a byte-level SHA3 padding model.
// -----------------------------------------------------------------------------
module tb_sha3_pad_packer;

   logic        ACLK = 1'b0;
   logic        ARESET;
   logic [1:0]  USER;
   logic [15:0] s_tdata;
   logic [1:0]  s_tkeep;
   logic        s_tvalid;
   logic        s_tlast;
   logic        s_tready;
   logic [15:0] m_tdata;
   logic        m_tvalid;
   logic        m_tready;
   logic        m_tlast;
   logic        m_tuser;
   logic        busy;

   int checks = 0;
   int errors = 0;

   always #5 ACLK = ~ACLK;

   sha3_pad_packer #(.WIDTH(16)) dut (
      .ACLK     (ACLK),
      .ARESET   (ARESET),
      .USER     (USER),
      .s_tdata  (s_tdata),
      .s_tkeep  (s_tkeep),
      .s_tvalid (s_tvalid),
      .s_tlast  (s_tlast),
      .s_tready (s_tready),
      .m_tdata  (m_tdata),
      .m_tvalid (m_tvalid),
      .m_tready (m_tready),
      .m_tlast  (m_tlast),
      .m_tuser  (m_tuser),
      .busy     (busy)
   );

   typedef struct {
      logic [1:0]  user;      // USER on the first word
      logic [1:0]  alt_user;  // USER on every later word
      int          nfull;     // full body words before the tail
      logic [15:0] base;      // body word i = base + i*0x0101
      logic [1:0]  tkeep;     // tail keep
      logic [15:0] tail;      // tail data
      bit          rnd;       // random downstream ready
      int          exp_n;     // expected output words
      logic [15:0] exp_w0;    // expected first word
      logic [15:0] exp_wl;    // expected last word
   } vec_t;

   vec_t        vecs[8];
   logic [17:0] exp_q[$];     // {tuser, tlast, data}

   task automatic check(input string name, input logic [17:0] act, input logic [17:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   function automatic int rate_words(input logic [1:0] u);
      case (u)
         2'd0:    return 72;
         2'd1:    return 68;
         2'd2:    return 52;
         default: return 36;
      endcase
   endfunction

   // Textbook SHA3 padding on a byte string, then split into 16-bit words.
   task automatic build_exp(input vec_t v);
      logic [7:0]  pad [0:1023];
      logic [15:0] w;
      int len, rb, total, r;
      for (int i = 0; i < 1024; i++) pad[i] = 8'h00;
      len = 0;
      for (int i = 0; i < v.nfull; i++) begin
         w = v.base + 16'(i) * 16'h0101;
         pad[len]   = w[7:0];
         pad[len+1] = w[15:8];
         len += 2;
      end
      if (v.tkeep[1]) begin
         pad[len]   = v.tail[7:0];
         pad[len+1] = v.tail[15:8];
         len += 2;
      end else if (v.tkeep[0]) begin
         pad[len] = v.tail[7:0];
         len += 1;
      end
      r     = rate_words(v.user);
      rb    = 2 * r;
      total = (len / rb + 1) * rb;
      pad[len]       = pad[len] ^ 8'h06;
      pad[total-1]   = pad[total-1] ^ 8'h80;
      exp_q.delete();
      for (int k = 0; k < total / 2; k++) begin
         exp_q.push_back({(k == total / 2 - 1), ((k % r) == r - 1), pad[2*k+1], pad[2*k]});
      end
   endtask

   task automatic run_vec(input int id, input vec_t v);
      int nwords, idx, nout, cyc;
      bit prev_stall;
      logic [15:0] prev_data;
      build_exp(v);
      nwords     = v.nfull + 1;
      idx        = 0;
      nout       = 0;
      cyc        = 0;
      prev_stall = 1'b0;
      prev_data  = '0;
      while (nout < v.exp_n && cyc < 3000) begin
         @(negedge ACLK);
         cyc++;
         if (idx < nwords) begin
            s_tvalid = 1'b1;
            USER     = (idx == 0) ? v.user : v.alt_user;
            if (idx < v.nfull) begin
               s_tdata = v.base + 16'(idx) * 16'h0101;
               s_tkeep = 2'b11;
               s_tlast = 1'b0;
            end else begin
               s_tdata = v.tail;
               s_tkeep = v.tkeep;
               s_tlast = 1'b1;
            end
         end else begin
            s_tvalid = 1'b0;
            s_tlast  = 1'b0;
            s_tkeep  = 2'b11;
         end
         m_tready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         if (prev_stall) check($sformatf("v%0d stall_hold", id), 18'(m_tdata), 18'(prev_data));
         if (m_tvalid && !m_tready) check($sformatf("v%0d stall_s_tready", id), 18'(s_tready), 18'd0);
         if (s_tvalid && s_tready) idx++;
         if (m_tvalid && m_tready) begin
            if (nout < exp_q.size())
               check($sformatf("v%0d word%0d", id, nout), {m_tuser, m_tlast, m_tdata}, exp_q[nout]);
            else
               check($sformatf("v%0d extra_word%0d", id, nout), 18'(exp_q.size()), 18'(nout + 1));
            if (nout == 0) check($sformatf("v%0d first_word", id), 18'(m_tdata), 18'(v.exp_w0));
            if (nout == v.exp_n - 1) check($sformatf("v%0d last_word", id), 18'(m_tdata), 18'(v.exp_wl));
            check($sformatf("v%0d busy_active", id), 18'(busy), 18'd1);
            nout++;
         end
         prev_stall = m_tvalid && !m_tready;
         prev_data  = m_tdata;
      end
      if (nout < v.exp_n) check($sformatf("v%0d timeout_words", id), 18'(nout), 18'(v.exp_n));
      @(negedge ACLK);
      s_tvalid = 1'b0;
      m_tready = 1'b1;
      #1;
      check($sformatf("v%0d busy_after", id), 18'(busy), 18'd0);
      check($sformatf("v%0d no_extra_valid", id), 18'(m_tvalid), 18'd0);
   endtask

   task automatic reset_mid_message();
      int acc, cyc;
      acc = 0;
      cyc = 0;
      while (acc < 10 && cyc < 200) begin
         @(negedge ACLK);
         cyc++;
         USER     = 2'd3;
         s_tvalid = 1'b1;
         s_tdata  = 16'h5500 + 16'(acc);
         s_tkeep  = 2'b11;
         s_tlast  = 1'b0;
         m_tready = 1'b1;
         #1;
         if (s_tready) acc++;
      end
      check("rst_words_accepted", 18'(acc), 18'd10);
      @(negedge ACLK);
      ARESET   = 1'b1;
      s_tvalid = 1'b0;
      @(negedge ACLK);
      #1;
      check("rst_m_tvalid", 18'(m_tvalid), 18'd0);
      check("rst_m_tdata", 18'(m_tdata), 18'd0);
      check("rst_m_tlast", 18'(m_tlast), 18'd0);
      check("rst_m_tuser", 18'(m_tuser), 18'd0);
      check("rst_busy", 18'(busy), 18'd0);
      ARESET = 1'b0;
      @(negedge ACLK);
      #1;
      check("rst_s_tready", 18'(s_tready), 18'd1);
   endtask

   initial begin
      //          user  alt   nfull base      keep   tail      rnd  n   w0        wl
      vecs[0] = '{2'd3, 2'd3, 0,    16'h0000, 2'b00, 16'h0000, 0,  36, 16'h0006, 16'h8000};
      vecs[1] = '{2'd1, 2'd1, 1,    16'h6261, 2'b01, 16'h0063, 0,  68, 16'h6261, 16'h8000};
      vecs[2] = '{2'd3, 2'd3, 35,   16'h1000, 2'b01, 16'h00AB, 0,  36, 16'h1000, 16'h86AB};
      vecs[3] = '{2'd3, 2'd3, 35,   16'h1000, 2'b11, 16'hC0DE, 0,  72, 16'h1000, 16'h8000};
      vecs[4] = '{2'd1, 2'd1, 1,    16'h6261, 2'b01, 16'h0063, 1,  68, 16'h6261, 16'h8000};
      vecs[5] = '{2'd3, 2'd0, 5,    16'h2000, 2'b11, 16'h3030, 0,  36, 16'h2000, 16'h8000};
      vecs[6] = '{2'd2, 2'd2, 2,    16'h4000, 2'b10, 16'hBEEF, 0,  52, 16'h4000, 16'h8000};
      vecs[7] = '{2'd0, 2'd0, 0,    16'h0000, 2'b00, 16'h0000, 0,  72, 16'h0006, 16'h8000};

      ARESET   = 1'b1;
      USER     = 2'd0;
      s_tdata  = '0;
      s_tkeep  = 2'b11;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      m_tready = 1'b1;
      repeat (2) @(negedge ACLK);
      #1;
      check("init_m_tvalid", 18'(m_tvalid), 18'd0);
      check("init_m_tdata", 18'(m_tdata), 18'd0);
      check("init_m_tlast", 18'(m_tlast), 18'd0);
      check("init_m_tuser", 18'(m_tuser), 18'd0);
      check("init_busy", 18'(busy), 18'd0);
      check("init_s_tready", 18'(s_tready), 18'd1);
      ARESET = 1'b0;

      for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);
      reset_mid_message();
      run_vec(7, vecs[7]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
